pulse_train_gen: RTL

- Edge/level generator: the transmit-side counterpart to the edge detectors in Part3.
- On a start command it drives a programmable train of high pulses on d_out.
- It also emits one-cycle rise_edge/fall_edge strobes aligned with the transitions it creates.
- Used to stimulate and pace downstream logic that consumes edges, e.g. a detector under test or a handshake line.

---
 rtl/pulse_train_gen_if.sv | 25 ++
 rtl/pulse_train_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pulse_train_gen_if.sv
// rtl/pulse_train_gen_if.sv - command/config and waveform signals of the pulse train generator
interface pulse_train_gen_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] num_pulses;
    logic             abort;
    logic             d_out;
    logic             rise_edge;
    logic             fall_edge;
    logic             busy;
    logic             done;

    modport master (
        output start, high_len, low_len, num_pulses, abort,
        input  d_out, rise_edge, fall_edge, busy, done
    );

    modport slave (
        input  start, high_len, low_len, num_pulses, abort,
        output d_out, rise_edge, fall_edge, busy, done
    );
endinterface

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable pulse train with registered rise/fall/done strobes
module pulse_train_gen #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    pulse_train_gen_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] r_left;
    logic [CNT_W-1:0] w_left_nx;
    logic [CNT_W-1:0] r_high_len;
    logic [CNT_W-1:0] w_high_len_nx;
    logic [CNT_W-1:0] r_low_len;
    logic [CNT_W-1:0] w_low_len_nx;
    logic             r_d_out;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;
    logic             r_done;
    logic             w_d_nx;
    logic             w_rise_nx;
    logic             w_fall_nx;
    logic             w_done_nx;
    logic             w_accept;
    logic [CNT_W-1:0] w_low_cycles;

    assign w_accept = bus.start && !bus.abort
                   && (bus.num_pulses != '0) && (bus.high_len != '0);

    // A zero low length still yields one low cycle so both edges stay visible.
    assign w_low_cycles = (r_low_len == '0) ? CNT_W'(1) : r_low_len;

    // r_cnt holds the cycles remaining in the current phase, including this one.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_left_nx     = r_left;
        w_high_len_nx = r_high_len;
        w_low_len_nx  = r_low_len;
        w_d_nx        = 1'b0;
        w_rise_nx     = 1'b0;
        w_fall_nx     = 1'b0;
        w_done_nx     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx    = S_HIGH;
                    w_cnt_nx      = bus.high_len;
                    w_left_nx     = bus.num_pulses;
                    w_high_len_nx = bus.high_len;
                    w_low_len_nx  = bus.low_len;
                    w_d_nx        = 1'b1;
                    w_rise_nx     = 1'b1;
                end
            end
            S_HIGH: begin
                if (bus.abort) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                    w_left_nx  = '0;
                    w_fall_nx  = 1'b1;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_fall_nx = 1'b1;
                    if (r_left == CNT_W'(1)) begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = '0;
                        w_left_nx  = '0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_LOW;
                        w_cnt_nx   = w_low_cycles;
                        w_left_nx  = r_left - CNT_W'(1);
                    end
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                    w_d_nx   = 1'b1;
                end
            end
            S_LOW: begin
                if (bus.abort) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                    w_left_nx  = '0;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = r_high_len;
                    w_d_nx     = 1'b1;
                    w_rise_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_left_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_left     <= '0;
            r_high_len <= '0;
            r_low_len  <= '0;
            r_d_out    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_left     <= w_left_nx;
            r_high_len <= w_high_len_nx;
            r_low_len  <= w_low_len_nx;
            r_d_out    <= w_d_nx;
            r_rise     <= w_rise_nx;
            r_fall     <= w_fall_nx;
            r_busy     <= (w_state_nx != S_IDLE);
            r_done     <= w_done_nx;
        end
    end

    assign bus.d_out     = r_d_out;
    assign bus.rise_edge = r_rise;
    assign bus.fall_edge = r_fall;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
